// File: rtl/tspi_pkg.sv
// Shared TSPI types for the SD-card init sequencer.
// TSPI_INIT_CMD59_EN inserts CMD59 (CRC on) between CMD8 and CMD58.
package tspi_pkg;

  typedef enum logic [2:0] {
    INIT_CMD0   = 3'd0,
    INIT_CMD8   = 3'd1,
    INIT_CMD59  = 3'd2,
    INIT_CMD58  = 3'd3,
    INIT_ACMD41 = 3'd4
  } init_cmd_e;

  typedef enum logic [2:0] {
    E_NONE    = 3'd0,
    E_CTRL    = 3'd1,
    E_TIMEOUT = 3'd2,
    E_R1      = 3'd3,
    E_RETRY   = 3'd4
  } init_err_e;

  localparam logic [7:0] R1_IDLE  = 8'h01;
  localparam logic [7:0] R1_READY = 8'h00;

  typedef struct packed {
    logic [7:0] baud_div;
  } config_reg_t;

  // Command that follows c once c has returned R1_IDLE.
  function automatic init_cmd_e next_cmd(input init_cmd_e c);
    init_cmd_e n;
    n = INIT_ACMD41;
    case (c)
      INIT_CMD0:  n = INIT_CMD8;
`ifdef TSPI_INIT_CMD59_EN
      INIT_CMD8:  n = INIT_CMD59;
`else
      INIT_CMD8:  n = INIT_CMD58;
`endif
      INIT_CMD59: n = INIT_CMD58;
      default:    n = INIT_ACMD41;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tspi_init_timer.sv
// Loadable saturating down-counter; expire_o flags the cycle whose edge takes it to zero.
module tspi_init_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                      cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Early by one cycle so a load of N yields exactly N enabled cycles.
  assign expire_o = (cnt_q <= W'(1));

endmodule

// File: rtl/tspi_init_seq.sv
// SD-card power-up sequencer: CMD0, CMD8, [CMD59], CMD58, ACMD41 poll, then fast baudrate.
// Build option: TSPI_INIT_CMD59_EN adds the CMD59 step (see tspi_pkg::next_cmd).
module tspi_init_seq
  import tspi_pkg::*;
#(
  parameter logic [7:0] InitBaudDiv      = 8'd200,
  parameter logic [7:0] FastBaudDiv      = 8'd2,
  parameter int         Acmd41MaxTries   = 1000,
  parameter int         PollDelayCycles  = 1024,
  parameter int         RspTimeoutCycles = 65535
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [2:0] err_code_o,
  output logic       cmd_req_o,
  output logic [2:0] cmd_id_o,
  input  logic       cmd_gnt_i,
  input  logic       cmd_rvalid_i,
  input  logic       cmd_err_i,
  input  logic [7:0] cmd_r1_i,
  output logic       baud_we_o,
  output logic [7:0] baud_cfg_o
);

  localparam int RW  = $clog2(RspTimeoutCycles + 1);
  localparam int PW  = $clog2(PollDelayCycles + 1);
  localparam int TW  = (RW > PW) ? RW : PW;
  localparam int TRW = $clog2(Acmd41MaxTries + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SLOW_BAUD, S_ISSUE, S_WAIT_RSP, S_POLL_DLY, S_FAST_BAUD, S_DONE, S_FAIL
  } state_e;

  state_e          state_q, state_d;
  init_cmd_e       cmd_q, cmd_d;
  init_err_e       err_q, err_d;
  logic [TRW-1:0]  tries_q, tries_d, tries_inc;
  config_reg_t     cfg_q, cfg_d;

  logic            tmr_load, tmr_en, tmr_expire;
  logic [TW-1:0]   tmr_val;

  tspi_init_timer #(.W(TW)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .expire_o   (tmr_expire)
  );

  assign tries_inc = (tries_q == TRW'(Acmd41MaxTries)) ? tries_q : tries_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    err_d    = err_q;
    tries_d  = tries_q;
    cfg_d    = cfg_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          state_d = S_SLOW_BAUD;
          err_d   = E_NONE;
          tries_d = '0;
          cmd_d   = INIT_CMD0;
        end
      end
      S_SLOW_BAUD: begin
        cfg_d.baud_div = InitBaudDiv;
        state_d        = S_ISSUE;
      end
      S_ISSUE: begin
        if (cmd_gnt_i) begin
          state_d  = S_WAIT_RSP;
          tmr_load = 1'b1;
          tmr_val  = TW'(RspTimeoutCycles);
        end
      end
      S_WAIT_RSP: begin
        tmr_en = 1'b1;
        if (cmd_err_i) begin
          state_d = S_FAIL;
          err_d   = E_CTRL;
        end else if (cmd_rvalid_i) begin
          if (cmd_q == INIT_ACMD41) begin
            if (cmd_r1_i == R1_READY) begin
              state_d = S_FAST_BAUD;
            end else if (cmd_r1_i == R1_IDLE) begin
              tries_d = tries_inc;
              if (tries_inc == TRW'(Acmd41MaxTries)) begin
                state_d = S_FAIL;
                err_d   = E_RETRY;
              end else begin
                state_d  = S_POLL_DLY;
                tmr_load = 1'b1;
                tmr_val  = TW'(PollDelayCycles);
              end
            end else begin
              state_d = S_FAIL;
              err_d   = E_R1;
            end
          end else if (cmd_r1_i == R1_IDLE) begin
            cmd_d   = next_cmd(cmd_q);
            state_d = S_ISSUE;
          end else begin
            state_d = S_FAIL;
            err_d   = E_R1;
          end
        end else if (tmr_expire) begin
          state_d = S_FAIL;
          err_d   = E_TIMEOUT;
        end
      end
      S_POLL_DLY: begin
        tmr_en = 1'b1;
        if (tmr_expire) state_d = S_ISSUE;
      end
      S_FAST_BAUD: begin
        cfg_d.baud_div = FastBaudDiv;
        state_d        = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cmd_q   <= INIT_CMD0;
      err_q   <= E_NONE;
      tries_q <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      tries_q <= tries_d;
      cfg_q   <= cfg_d;
    end
  end

  assign busy_o     = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
  assign done_o     = (state_q == S_DONE);
  assign fail_o     = (state_q == S_FAIL);
  assign err_code_o = err_q;
  assign cmd_req_o  = (state_q == S_ISSUE);
  assign cmd_id_o   = cmd_q;
  assign baud_we_o  = (state_q == S_SLOW_BAUD) || (state_q == S_FAST_BAUD);
  // Present the new divider alongside its write strobe; otherwise hold the last one written.
  always_comb begin
    baud_cfg_o = cfg_q.baud_div;
    if (state_q == S_SLOW_BAUD)      baud_cfg_o = InitBaudDiv;
    else if (state_q == S_FAST_BAUD) baud_cfg_o = FastBaudDiv;
  end

endmodule

// File: tb/tb_tspi_init_seq.sv
// Directed bench for tspi_init_seq with shortened timeout/poll/retry parameters.
module tb_tspi_init_seq;
  import tspi_pkg::*;

  logic       clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic       cmd_gnt_i = 1'b0, cmd_rvalid_i = 1'b0, cmd_err_i = 1'b0;
  logic [7:0] cmd_r1_i = 8'h00;
  logic       busy_o, done_o, fail_o, cmd_req_o, baud_we_o;
  logic [2:0] err_code_o, cmd_id_o;
  logic [7:0] baud_cfg_o;

  tspi_init_seq #(
    .InitBaudDiv(8'd200), .FastBaudDiv(8'd2), .Acmd41MaxTries(3),
    .PollDelayCycles(8), .RspTimeoutCycles(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .err_code_o(err_code_o),
    .cmd_req_o(cmd_req_o), .cmd_id_o(cmd_id_o), .cmd_gnt_i(cmd_gnt_i),
    .cmd_rvalid_i(cmd_rvalid_i), .cmd_err_i(cmd_err_i), .cmd_r1_i(cmd_r1_i),
    .baud_we_o(baud_we_o), .baud_cfg_o(baud_cfg_o)
  );

  always #5 clk = ~clk;

  int         tests = 0, fails = 0;
  logic [7:0] baud_log[$];
  logic [2:0] gnt_log[$];
  logic [2:0] exp_ord[$];
  int         req_cycles = 0;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (baud_we_o) baud_log.push_back(baud_cfg_o);
      if (cmd_req_o && cmd_gnt_i) gnt_log.push_back(cmd_id_o);
      if (cmd_req_o) req_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic grant_cmd(input string tag, input logic [2:0] id);
    int n = 0;
    while (!cmd_req_o && n < 200) begin tick(); n++; end
    chk({tag, "_req"}, 32'(cmd_req_o), 32'd1);
    chk({tag, "_id"}, 32'(cmd_id_o), 32'(id));
    cmd_gnt_i = 1'b1; tick(); cmd_gnt_i = 1'b0;
  endtask

  task automatic respond(input logic [7:0] r1, input logic err);
    tick(); tick();
    cmd_rvalid_i = 1'b1; cmd_err_i = err; cmd_r1_i = r1;
    tick();
    cmd_rvalid_i = 1'b0; cmd_err_i = 1'b0; cmd_r1_i = 8'h00;
  endtask

  task automatic serve(input string tag, input logic [2:0] id, input logic [7:0] r1);
    grant_cmd(tag, id);
    respond(r1, 1'b0);
  endtask

  task automatic serve_cmd8_59(input string tag);
    serve({tag, "_cmd8"}, 3'(INIT_CMD8), R1_IDLE);
`ifdef TSPI_INIT_CMD59_EN
    serve({tag, "_cmd59"}, 3'(INIT_CMD59), R1_IDLE);
`endif
  endtask

  task automatic to_acmd41(input string tag);
    serve({tag, "_cmd0"}, 3'(INIT_CMD0), R1_IDLE);
    serve_cmd8_59(tag);
    serve({tag, "_cmd58"}, 3'(INIT_CMD58), R1_IDLE);
  endtask

  task automatic run_nominal(input string tag);
    int n = 0;
    baud_log.delete(); gnt_log.delete();
    do_start();
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    chk({tag, "_slow_we"}, 32'(baud_we_o), 32'd1);
    chk({tag, "_slow_cfg"}, 32'(baud_cfg_o), 32'd200);
    to_acmd41(tag);
    serve({tag, "_a41_1"}, 3'(INIT_ACMD41), R1_IDLE);
    serve({tag, "_a41_2"}, 3'(INIT_ACMD41), R1_IDLE);
    serve({tag, "_a41_3"}, 3'(INIT_ACMD41), R1_READY);
    while (!done_o && n < 50) begin tick(); n++; end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_idle"}, {29'd0, busy_o, fail_o, 1'b0}, 32'd0);
    chk({tag, "_baud_n"}, 32'(baud_log.size()), 32'd2);
    chk({tag, "_baud0"}, 32'(baud_log[0]), 32'd200);
    chk({tag, "_baud1"}, 32'(baud_log[1]), 32'd2);
    chk({tag, "_cfg"}, 32'(baud_cfg_o), 32'd2);
    chk({tag, "_gnt_n"}, 32'(gnt_log.size()), 32'(exp_ord.size()));
    for (int i = 0; i < exp_ord.size(); i++)
      chk($sformatf("%s_ord%0d", tag, i), 32'(gnt_log[i]), 32'(exp_ord[i]));
  endtask

  initial begin
    int n;
    int r;
    int a41;
    exp_ord = '{3'(INIT_CMD0), 3'(INIT_CMD8),
`ifdef TSPI_INIT_CMD59_EN
                3'(INIT_CMD59),
`endif
                3'(INIT_CMD58), 3'(INIT_ACMD41), 3'(INIT_ACMD41), 3'(INIT_ACMD41)};

    // reset state
    #1;
    chk("reset_outs", {busy_o, done_o, fail_o, err_code_o, cmd_req_o, baud_we_o, baud_cfg_o}, 32'd0);
    tick(); tick(); rst_ni = 1'b1; tick();
    chk("post_reset_idle", {busy_o, done_o, fail_o, cmd_req_o}, 32'd0);

    // 1 nominal
    run_nominal("nom");

    // 2 bad R1 on CMD0
    baud_log.delete();
    do_start();
    chk("badr1_clear", {done_o, fail_o, err_code_o}, 32'd0);
    serve("badr1_cmd0", 3'(INIT_CMD0), 8'h05);
    chk("badr1_fail", 32'(fail_o), 32'd1);
    chk("badr1_err", 32'(err_code_o), 32'(E_R1));
    chk("badr1_busy", 32'(busy_o), 32'd0);
    r = req_cycles;
    repeat (20) tick();
    chk("badr1_noreq", 32'(req_cycles), 32'(r));
    chk("badr1_baud_n", 32'(baud_log.size()), 32'd1);
    chk("badr1_cfg", 32'(baud_cfg_o), 32'd200);

    // 3 timeout: fail exactly 16 cycles after the CMD8 grant edge
    do_start();
    serve("tmo_cmd0", 3'(INIT_CMD0), R1_IDLE);
    grant_cmd("tmo_cmd8", 3'(INIT_CMD8));
    repeat (15) tick();
    chk("tmo_early", 32'(fail_o), 32'd0);
    tick();
    chk("tmo_fail", 32'(fail_o), 32'd1);
    chk("tmo_err", 32'(err_code_o), 32'(E_TIMEOUT));

    // 4 retry exhaustion with poll spacing
    gnt_log.delete();
    do_start();
    to_acmd41("rty");
    for (int k = 0; k < 2; k++) begin
      serve($sformatf("rty_a41_%0d", k), 3'(INIT_ACMD41), R1_IDLE);
      n = 0;
      while (!cmd_req_o && n < 100) begin tick(); n++; end
      chk($sformatf("rty_dly%0d", k), 32'(n), 32'd8);
    end
    serve("rty_a41_2", 3'(INIT_ACMD41), R1_IDLE);
    chk("rty_fail", 32'(fail_o), 32'd1);
    chk("rty_err", 32'(err_code_o), 32'(E_RETRY));
    a41 = 0;
    foreach (gnt_log[i]) if (gnt_log[i] == 3'(INIT_ACMD41)) a41++;
    chk("rty_a41_cnt", 32'(a41), 32'd3);

    // 5 start while busy ignored; controller error beats rvalid
    baud_log.delete();
    do_start();
    grant_cmd("ctl_cmd0", 3'(INIT_CMD0));
    do_start();
    respond(R1_IDLE, 1'b0);
    chk("ctl_busy", 32'(busy_o), 32'd1);
    chk("ctl_baud_n", 32'(baud_log.size()), 32'd1);
    serve_cmd8_59("ctl");
    grant_cmd("ctl_cmd58", 3'(INIT_CMD58));
    respond(R1_IDLE, 1'b1);
    chk("ctl_fail", 32'(fail_o), 32'd1);
    chk("ctl_err", 32'(err_code_o), 32'(E_CTRL));

    // 6 reset during ACMD41 poll, then a full restart
    do_start();
    to_acmd41("rst");
    serve("rst_a41", 3'(INIT_ACMD41), R1_IDLE);
    chk("rst_in_poll", {busy_o, cmd_req_o}, 32'h2);
    rst_ni = 1'b0; #1;
    chk("rst_outs", {busy_o, done_o, fail_o, err_code_o, cmd_req_o, cmd_id_o, baud_we_o, baud_cfg_o}, 32'd0);
    tick(); rst_ni = 1'b1; tick();
    run_nominal("rst_nom");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
